// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank: synchronises, debounces and times the board push-buttons.
// Each bit yields a clean level, press/release pulses, a hold flag and auto-repeat.
module btn_debounce_bank #(
    parameter int NBTN          = 5,
    parameter int DB_CYCLES     = 400000,
    parameter int HOLD_CYCLES   = 20000000,
    parameter int REPEAT_CYCLES = 4000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_dn,
    output logic [NBTN-1:0] btn_up,
    output logic [NBTN-1:0] btn_hold,
    output logic [NBTN-1:0] btn_rpt
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam int RW  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  H_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]  H_MAX   = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0]  R_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_QUAL,
        PRESSED,
        HELD,
        RELEASE_QUAL
    } state_e;

    logic [NBTN-1:0] s1_q, s1_d;
    logic [NBTN-1:0] s2_q, s2_d;

    // Two-flop synchroniser input path.
    always_comb begin
        s1_d = btn_raw;
        s2_d = s1_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        state_e         state_q, state_d;
        logic           level_q, level_d;
        logic           dn_q, dn_d;
        logic           up_q, up_d;
        logic           hold_q, hold_d;
        logic           rpt_q, rpt_d;
        logic [DBW-1:0] db_q, db_d;
        logic [HW-1:0]  hcnt_q, hcnt_d;
        logic [RW-1:0]  rcnt_q, rcnt_d;
        logic           active;
        logic           mismatch;
        logic           done;
        logic           in_qual;
        logic           hold_rise;

        // Debounce qualification, hold/repeat timing and state tracking.
        always_comb begin
            active = (state_q == PRESSED) || (state_q == HELD) ||
                     (state_q == RELEASE_QUAL);
            mismatch = (s2_q[i] != level_q);
            done = mismatch && (db_q == DB_LAST);
            in_qual = mismatch && !done;

            db_d = in_qual ? db_q + DBW'(1) : '0;
            level_d = level_q ^ done;
            dn_d = done && !level_q;
            up_d = done && level_q;

            hold_rise = active && !hold_q && !up_d && (hcnt_q == H_LAST);

            hcnt_d = hcnt_q;
            if (dn_d || up_d) begin
                hcnt_d = '0;
            end else if (active && (hcnt_q != H_MAX)) begin
                hcnt_d = hcnt_q + HW'(1);
            end

            hold_d = !up_d && (hold_q || hold_rise);

            rcnt_d = '0;
            if (!up_d && hold_q) begin
                rcnt_d = (rcnt_q == R_LAST) ? '0 : rcnt_q + RW'(1);
            end

            rpt_d = !up_d && (hold_rise || (hold_q && (rcnt_q == R_LAST)));

            state_d = state_q;
            unique case (1'b1)
                (!level_d && !in_qual): state_d = RELEASED;
                (!level_d && in_qual):  state_d = PRESS_QUAL;
                (level_d && in_qual):   state_d = RELEASE_QUAL;
                (level_d && !in_qual && hold_d): state_d = HELD;
                default:                state_d = PRESSED;
            endcase
        end

        // Per-button state registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= RELEASED;
                level_q <= 1'b0;
                dn_q    <= 1'b0;
                up_q    <= 1'b0;
                hold_q  <= 1'b0;
                rpt_q   <= 1'b0;
                db_q    <= '0;
                hcnt_q  <= '0;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                level_q <= level_d;
                dn_q    <= dn_d;
                up_q    <= up_d;
                hold_q  <= hold_d;
                rpt_q   <= rpt_d;
                db_q    <= db_d;
                hcnt_q  <= hcnt_d;
                rcnt_q  <= rcnt_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_dn[i]    = dn_q;
        assign btn_up[i]    = up_q;
        assign btn_hold[i]  = hold_q;
        assign btn_rpt[i]   = rpt_q;
    end

endmodule

// File: doc/btn_debounce_bank.md
# btn_debounce_bank

Conditions the five raw board push-buttons (left, right, up, down, centre) into clean, clock-synchronous signals for the control core. It sits between the FPGA button pins and the core's per-button input-mode stage. For each button it provides:
- a debounced level;
- one-cycle press and release pulses;
- a hold flag and an auto-repeat pulse train for held buttons.

All buttons are processed by identical, independent per-bit logic.

## Interface
Parameters:
- NBTN, 5, number of buttons. Bit order: 0=left, 1=right, 2=up, 3=down, 4=centre.
- DB_CYCLES, 400000, consecutive stable cycles required to accept a change (10 ms at 40 MHz). Must be ≥1.
- HOLD_CYCLES, 20000000, cycles after press before hold asserts (0.5 s). Must be ≥1.
- REPEAT_CYCLES, 4000000, period of repeat pulses while hold is asserted (0.1 s). Must be ≥1.

Ports:
- clk  in  1  clock, same domain as the core.
- rst  in  1  reset, synchronous, active-high.
- btn_raw  in  NBTN  asynchronous raw button pins, active-high.
- btn_level  out  NBTN  debounced level.
- btn_dn  out  NBTN  one-cycle pulse on accepted press.
- btn_up  out  NBTN  one-cycle pulse on accepted release.
- btn_hold  out  NBTN  high while held ≥ HOLD_CYCLES.
- btn_rpt  out  NBTN  one-cycle auto-repeat pulse.

## Operation
- **Synchroniser:** each btn_raw bit passes through 2 flops, s1 then s2. Both reset to 0. Debounce logic uses s2 only.
- **Debounce counter:** one counter per button, width $clog2(DB_CYCLES+1).
  - While s2 != btn_level, the counter increments each cycle.
  - On any cycle with s2 == btn_level, the counter clears to 0. Any bounce therefore restarts qualification.
  - On the cycle the counter equals DB_CYCLES-1 and s2 != btn_level:
    - btn_level toggles;
    - the counter clears;
    - btn_dn (rising) or btn_up (falling) pulses for exactly that one cycle, registered with the level change.
- **Per-button FSM states:**
  - RELEASED: level 0, counter idle.
  - PRESS_QUAL: s2=1, counting. Returns to RELEASED if s2 drops; goes to PRESSED when qualification completes.
  - PRESSED: level 1, hold timer running.
  - HELD: level 1, hold asserted, repeat timer running.
  - RELEASE_QUAL: s2=0 while level is 1, counting. Goes back to PRESSED or HELD if s2 returns to 1; goes to RELEASED when qualification completes.
  - The hold and repeat timers keep running during RELEASE_QUAL.
- **Hold timer:**
  - Clears to 0 on the btn_dn cycle and increments each cycle while level is 1. Width $clog2(HOLD_CYCLES+1); saturates and does not wrap.
  - btn_hold rises HOLD_CYCLES cycles after the btn_dn cycle.
  - On that same cycle btn_rpt pulses, and the repeat timer loads 0.
- **Repeat timer:**
  - While hold is high, it counts 0..REPEAT_CYCLES-1 and wraps.
  - btn_rpt pulses each time the timer wraps to 0, i.e. every REPEAT_CYCLES cycles after the first repeat.
- **Release:** on the btn_up cycle, btn_hold drops, btn_rpt is 0, and the hold and repeat timers clear.
- **Independence:** buttons never interact. Simultaneous presses on several bits produce simultaneous pulses.

## Timing
- **Reset value:** every output and internal register is 0 on the clock edge where rst=1.
- **Reset mid-press:** if a button is held through reset, it is treated as a fresh press after rst falls. btn_dn follows after the full latency, with no btn_up emitted.
- **Press latency:** btn_raw rises stably before edge 1. Then:
  - s2=1 after edge 2;
  - btn_level and btn_dn are 1 after edge DB_CYCLES+2.
- **Release latency:** symmetric to press latency.
- **Pulse width:** btn_dn, btn_up and btn_rpt are exactly 1 cycle wide. btn_dn and btn_up on the same bit never coincide.
- **Hold timing:** btn_hold rises HOLD_CYCLES edges after the btn_dn edge. Subsequent btn_rpt pulses occur every REPEAT_CYCLES edges.
- **REPEAT_CYCLES=1:** btn_rpt stays high every cycle while held.

## Test plan
All scenarios use DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- **Clean press:** raise bit 0 at edge 1 and hold for 8 cycles -> btn_level[0] and btn_dn[0] go high after edge 6. btn_dn[0] is low after edge 7. No other bits toggle.
- **Bounce rejection:** toggle bit 2 as 1,1,1,0,1,1,1,0 repeatedly (never 4 consecutive s2 highs) -> btn_level[2] stays 0 and there are no pulses. Then hold high -> btn_dn[2] fires 4 cycles after s2 settles.
- **Hold and repeat:** press bit 4 and keep it held -> btn_dn at edge 6; btn_hold and btn_rpt at edge 16; btn_rpt again at edges 19, 22, 25. Release -> btn_up and btn_hold fall after the same edge, and the repeat pulses stop.
- **Release bounce:** while bit 1 is held, drop raw for 2 cycles and then restore -> no btn_up, btn_level stays 1, and hold timing is unchanged.
- **Simultaneous press:** raise bits 0 and 3 on the same edge -> btn_dn = 5'b01001 for one cycle after edge 6.
- **Reset mid-hold:** assert rst for 1 cycle while bit 0 is HELD -> all outputs are 0 after that edge. With raw still high, btn_dn[0] re-fires DB_CYCLES+2 edges after rst falls, and no btn_up occurs.
